// File: rtl/pll_lock_monitor_if.sv
// Lock-monitor signal bundle: PLL lock/relock inputs plus the reset and status outputs.
// The monitor uses the master modport; the environment driving lock/relock uses slave.
interface pll_lock_monitor_if #(
    parameter int CNT_W = 8
) ();
    logic             lock;
    logic             relock_req;
    logic             pll_reset;
    logic             sys_rst;
    logic [1:0]       state;
    logic [CNT_W-1:0] timeout_cnt;
    logic [CNT_W-1:0] loss_cnt;

    modport master (
        input  lock,
        input  relock_req,
        output pll_reset,
        output sys_rst,
        output state,
        output timeout_cnt,
        output loss_cnt
    );

    modport slave (
        output lock,
        output relock_req,
        input  pll_reset,
        input  sys_rst,
        input  state,
        input  timeout_cnt,
        input  loss_cnt
    );
endinterface

// File: rtl/pll_lock_monitor.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable lock, releases the
// downstream system reset and counts lock timeouts and lock losses.
module pll_lock_monitor #(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int CNT_W               = 8
) (
    input  logic                 clkin,
    input  logic                 reset,
    pll_lock_monitor_if.master   bus
);

    localparam int MAX_A  = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
    localparam int MAX_P  = (MAX_A > LOCK_TIMEOUT_CYCLES) ? MAX_A : LOCK_TIMEOUT_CYCLES;
    localparam int CW     = $clog2(MAX_P);

    localparam logic [CW-1:0]    RST_LAST  = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0]    STB_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0]    TMO_LAST  = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] EVT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_PLL_RST   = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_STABLE    = 2'd2,
        ST_RUN       = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             lock_meta_q, lock_s_q;
    logic             sys_rst_q, sys_rst_d;
    logic [CNT_W-1:0] timeout_cnt_q, timeout_cnt_d;
    logic [CNT_W-1:0] loss_cnt_q, loss_cnt_d;
    logic             tmo_evt_s, loss_evt_s;
    logic             pll_reset_s;

    // State register, lock synchronizer, cycle counter and event counters.
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            state_q       <= ST_PLL_RST;
            cnt_q         <= '0;
            lock_meta_q   <= 1'b0;
            lock_s_q      <= 1'b0;
            sys_rst_q     <= 1'b1;
            timeout_cnt_q <= '0;
            loss_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            lock_meta_q   <= bus.lock;
            lock_s_q      <= lock_meta_q;
            sys_rst_q     <= sys_rst_d;
            timeout_cnt_q <= timeout_cnt_d;
            loss_cnt_q    <= loss_cnt_d;
        end
    end

    // Next-state decision; relock wins the destination but timeout/loss still count.
    always_comb begin
        state_d    = state_q;
        tmo_evt_s  = 1'b0;
        loss_evt_s = 1'b0;
        case (state_q)
            ST_PLL_RST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                end else begin
                    state_d = ST_PLL_RST;
                end
            end
            ST_WAIT_LOCK: begin
                tmo_evt_s = !lock_s_q && (cnt_q == TMO_LAST);
                if (bus.relock_req || tmo_evt_s) begin
                    state_d = ST_PLL_RST;
                end else if (lock_s_q) begin
                    state_d = ST_STABLE;
                end else begin
                    state_d = ST_WAIT_LOCK;
                end
            end
            ST_STABLE: begin
                if (bus.relock_req) begin
                    state_d = ST_PLL_RST;
                end else if (!lock_s_q) begin
                    state_d = ST_WAIT_LOCK;
                end else if (cnt_q == STB_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_STABLE;
                end
            end
            ST_RUN: begin
                loss_evt_s = !lock_s_q;
                if (bus.relock_req || loss_evt_s) begin
                    state_d = ST_PLL_RST;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_PLL_RST;
            end
        endcase
    end

    // Counter and output next values; the cycle counter idles in RUN where nothing is timed.
    always_comb begin
        cnt_d         = cnt_q;
        timeout_cnt_d = timeout_cnt_q;
        loss_cnt_d    = loss_cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q != ST_RUN) begin
            cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
        if (tmo_evt_s && (timeout_cnt_q != EVT_MAX)) begin
            timeout_cnt_d = timeout_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            timeout_cnt_d = timeout_cnt_q;
        end
        if (loss_evt_s && (loss_cnt_q != EVT_MAX)) begin
            loss_cnt_d = loss_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            loss_cnt_d = loss_cnt_q;
        end
        sys_rst_d   = (state_d != ST_RUN);
        pll_reset_s = (state_q == ST_PLL_RST);
    end

    assign bus.pll_reset   = pll_reset_s;
    assign bus.sys_rst     = sys_rst_q;
    assign bus.state       = state_q;
    assign bus.timeout_cnt = timeout_cnt_q;
    assign bus.loss_cnt    = loss_cnt_q;

endmodule
